// File: rtl/niosii_system_data_format_adapter_1_data_reader.sv
`default_nettype none
// ============================================================================
// Module      : niosii_system_data_format_adapter_1_data_reader
// Description : Read-side sequencer for the adapter symbol RAM. It walks the
//               RAM from a start address for a given number of symbols and
//               absorbs the RAM's two-cycle read latency. Symbols leave as an
//               Avalon-ST source with ready/valid backpressure and packet
//               delimiters.
// Revision    : 1.0 - initial release
// ============================================================================
module niosii_system_data_format_adapter_1_data_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 1,
    parameter int DEPTH         = 2,
    parameter int LEN_WIDTH     = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_address,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     done,
    input  logic                     mem_waitrequest,
    output logic [ADDRESS_WIDTH-1:0] rd_address,
    input  logic [DATA_WIDTH-1:0]    rd_readdata,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0]       c_fifo_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0]     c_len_one   = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Command / address generation
    logic [ADDRESS_WIDTH-1:0] r_rd_address;
    logic [LEN_WIDTH-1:0]     r_remaining;
    logic                     r_first;
    logic                     w_accept;
    logic                     w_issue;
    logic                     w_last_issue;

    // Read-latency tracking pipeline (stage 1 / stage 2)
    logic r_v1;
    logic r_v2;
    logic r_sop1;
    logic r_sop2;
    logic r_eop1;
    logic r_eop2;

    // Output FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic                  r_fifo_sop  [FIFO_DEPTH];
    logic                  r_fifo_eop  [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_fifo_count;
    logic [c_cnt_w-1:0]    w_in_use;
    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_eop;

    logic r_done;

    // Credit: reads already issued but not yet landed count against FIFO space
    assign w_in_use     = c_cnt_w'(r_v1) + c_cnt_w'(r_v2) + r_fifo_count;
    assign w_not_empty  = (r_fifo_count != '0);
    assign w_push       = r_v2;
    assign w_pop        = w_not_empty && out_ready;
    assign w_head_eop   = w_not_empty && r_fifo_eop[r_rd_ptr];
    assign w_last_issue = (r_remaining == c_len_one);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, command acceptance and read-issue decisions
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !mem_waitrequest && (length != '0)) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (w_in_use < c_fifo_full) begin
                    w_issue = 1'b1;
                    if (w_last_issue) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head_eop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Address counter with wrap at DEPTH-1 and remaining-symbol countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_address <= '0;
            r_remaining  <= '0;
            r_first      <= 1'b0;
        end else if (w_accept) begin
            r_rd_address <= start_address;
            r_remaining  <= length;
            r_first      <= 1'b1;
        end else if (w_issue) begin
            r_rd_address <= (r_rd_address == c_last_addr) ? '0
                          : r_rd_address + ADDRESS_WIDTH'(1);
            r_remaining  <= r_remaining - c_len_one;
            r_first      <= 1'b0;
        end
    end

    // Two-stage marker of issued cycles; packet tags travel alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_sop1 <= 1'b0;
            r_sop2 <= 1'b0;
            r_eop1 <= 1'b0;
            r_eop2 <= 1'b0;
        end else begin
            r_v1   <= w_issue;
            r_sop1 <= w_issue && r_first;
            r_eop1 <= w_issue && w_last_issue;
            r_v2   <= r_v1;
            r_sop2 <= r_sop1;
            r_eop2 <= r_eop1;
        end
    end

    // FIFO storage; contents are don't-care while empty since outputs are masked
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= rd_readdata;
            r_fifo_sop[r_wr_ptr]  <= r_sop2;
            r_fifo_eop[r_wr_ptr]  <= r_eop2;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_cnt_w'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_cnt_w'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // One-cycle completion pulse following the endofpacket transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_pop && w_head_eop;
        end
    end

    assign busy              = (r_state != ST_IDLE);
    assign done              = r_done;
    assign rd_address        = r_rd_address;
    assign out_valid         = w_not_empty;
    assign out_data          = w_not_empty ? r_fifo_data[r_rd_ptr] : '0;
    assign out_startofpacket = w_not_empty && r_fifo_sop[r_rd_ptr];
    assign out_endofpacket   = w_head_eop;

endmodule
`default_nettype wire

// File: tb/tb_niosii_system_data_format_adapter_1_data_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_niosii_system_data_format_adapter_1_data_reader
// Description : Self-checking bench with a two-cycle-latency RAM model, a
//               queue-based expected-symbol model and randomized backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_niosii_system_data_format_adapter_1_data_reader;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int LW  = 16;
    localparam int FD  = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_address;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          mem_waitrequest;
    logic [AW-1:0] rd_address;
    logic [DW-1:0] rd_readdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_startofpacket;
    logic          out_endofpacket;

    niosii_system_data_format_adapter_1_data_reader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEP),
        .LEN_WIDTH     (LW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_address     (start_address),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .mem_waitrequest   (mem_waitrequest),
        .rd_address        (rd_address),
        .rd_readdata       (rd_readdata),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data appears two cycles after the address cycle
    logic [DW-1:0] mem [DEP];
    logic [DW-1:0] ram_p1;
    logic [DW-1:0] ram_p2;
    always @(posedge clk) begin
        ram_p1 <= mem[rd_address];
        ram_p2 <= ram_p1;
    end
    assign rd_readdata = ram_p2;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Expected symbols {sop, eop, data}
    logic [DW+1:0] exp_q [$];

    task automatic push_packet(input int addr, input int len);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back({(k == 0), (k == len - 1), mem[(addr + k) % DEP]});
        end
    endtask

    // Monitor state
    int start_cycle       = 0;
    int first_valid_cycle = -1;
    int last_eop_cycle    = -100;
    int busy_seen         = 0;
    int done_seen         = 0;
    int valid_seen        = 0;
    int max_count         = 0;
    bit prev_stall        = 1'b0;
    logic [DW+1:0] prev_sym;
    bit bp_mode           = 1'b0;
    int stall_left        = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (int'(dut.r_fifo_count) > max_count) max_count = int'(dut.r_fifo_count);
                if (busy) busy_seen++;
                if (out_valid) valid_seen++;
                if (out_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'({out_startofpacket, out_endofpacket, out_data}), 32'(prev_sym));
                end
                if (done) begin
                    done_seen++;
                    check("done_timing", 32'(cycle), 32'(last_eop_cycle + 1));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_symbol", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        check("symbol", 32'({out_startofpacket, out_endofpacket, out_data}),
                              32'(exp_q.pop_front()));
                    end
                    if (out_endofpacket) last_eop_cycle = cycle;
                end
                prev_stall = out_valid && !out_ready;
                prev_sym   = {out_startofpacket, out_endofpacket, out_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Ready driver: random 2-cycle stalls when backpressure is enabled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if ($urandom_range(0, 2) == 0) begin
                    out_ready  = 1'b0;
                    stall_left = 1;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready  = 1'b1;
                stall_left = 0;
            end
        end
    end

    task automatic start_pkt(input int addr, input int len, input bit accept, input bit align);
        if (align) begin
            @(posedge clk);
            #1;
        end
        start         = 1'b1;
        start_address = AW'(addr);
        length        = LW'(len);
        if (accept) begin
            push_packet(addr, len);
            start_cycle       = cycle;
            first_valid_cycle = -1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
        check("done_within_budget", 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_addr"},  32'(rd_address), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data), 32'd0);
        check({tag, "_sop"},   32'(out_startofpacket), 32'd0);
        check({tag, "_eop"},   32'(out_endofpacket), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        start_address   = '0;
        length          = '0;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < DEP; i++) mem[i] = DW'(i + 8'h10);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Length 0 is a no-op
        busy_seen = 0; done_seen = 0; valid_seen = 0;
        start_pkt(5, 0, 1'b0, 1'b1);
        idle(8);
        check("len0_busy", 32'(busy_seen), 32'd0);
        check("len0_done", 32'(done_seen), 32'd0);
        check("len0_valid", 32'(valid_seen), 32'd0);

        // Basic packet and latency
        start_pkt(3, 5, 1'b1, 1'b1);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_addr", 32'(rd_address), 32'd3);
        wait_done(60);
        check("first_valid_latency", 32'(first_valid_cycle - start_cycle), 32'd4);
        check("eop_latency", 32'(last_eop_cycle - start_cycle), 32'd8);
        check("basic_drained", 32'(exp_q.size()), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);

        // Address wrap
        start_pkt(14, 4, 1'b1, 1'b1);
        wait_done(60);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure
        bp_mode = 1'b1;
        start_pkt(0, 8, 1'b1, 1'b1);
        wait_done(300);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        bp_mode = 1'b0;
        idle(2);

        // Start gated by mem_waitrequest
        busy_seen = 0; valid_seen = 0;
        @(posedge clk);
        #1;
        mem_waitrequest = 1'b1;
        start_pkt(2, 3, 1'b0, 1'b0);
        mem_waitrequest = 1'b0;
        idle(6);
        check("waitreq_busy", 32'(busy_seen), 32'd0);
        check("waitreq_valid", 32'(valid_seen), 32'd0);

        // Start during READ is ignored
        start_pkt(1, 6, 1'b1, 1'b1);
        start_pkt(9, 3, 1'b0, 1'b0);
        wait_done(60);
        busy_seen = 0; valid_seen = 0;
        idle(8);
        check("ignored_start_busy", 32'(busy_seen), 32'd0);
        check("ignored_start_valid", 32'(valid_seen), 32'd0);
        check("ignored_start_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back start in the done cycle
        start_pkt(4, 3, 1'b1, 1'b1);
        wait_done(60);
        start_pkt(7, 2, 1'b1, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_addr", 32'(rd_address), 32'd7);
        wait_done(60);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the third cycle of a 10-symbol packet
        start_pkt(0, 10, 1'b1, 1'b1);
        idle(1);
        idle(1);
        reset = 1'b1;
        exp_q.delete();
        done_seen = 0;
        idle(1);
        reset = 1'b0;
        check_reset_outputs("midreset");
        valid_seen = 0;
        idle(10);
        check("midreset_no_done", 32'(done_seen), 32'd0);
        check("midreset_no_valid", 32'(valid_seen), 32'd0);
        start_pkt(5, 4, 1'b1, 1'b1);
        wait_done(60);
        check("post_reset_drained", 32'(exp_q.size()), 32'd0);

        // Randomized packets with random RAM contents
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEP; i++) mem[i] = DW'($urandom);
            bp_mode = 1'($urandom_range(0, 1));
            start_pkt(int'($urandom_range(0, DEP - 1)), int'($urandom_range(1, 20)), 1'b1, 1'b1);
            wait_done(500);
            check("rand_drained", 32'(exp_q.size()), 32'd0);
            bp_mode = 1'b0;
            idle(3);
        end

        check("fifo_never_over_depth", 32'(max_count <= FD), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
